// File: rtl/rf_wb_arb_if.sv
// rf_wb_arb_if: bus bundle for the register-file writeback arbiter.
// Carries flush, the three result sources (ALU, LSU, MUL), the pending-register
// scoreboard set/busy signals and the two RF write ports.
//   slave  : arbiter side (consumes results, drives RF ports and readies)
//   master : producer/consumer side (drives results, observes RF ports)
interface rf_wb_arb_if;
  logic        flush;

  logic        alu_wen;
  logic [3:0]  alu_wdst;
  logic        alu_wbank;
  logic [31:0] alu_wdata;

  logic        lsu_valid;
  logic [3:0]  lsu_wdst;
  logic        lsu_wbank;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;

  logic        mul_valid;
  logic [3:0]  mul_wdst;
  logic        mul_wbank;
  logic [31:0] mul_wdata;
  logic        mul_ready;

  logic        sb_set;
  logic [3:0]  sb_dst;
  logic        sb_bank;
  logic [23:0] sb_busy;

  logic        rf_wen0;
  logic [3:0]  rf_wdst0;
  logic        rf_wbank0;
  logic [31:0] rf_wdata0;
  logic        rf_wen1;
  logic [3:0]  rf_wdst1;
  logic        rf_wbank1;
  logic [31:0] rf_wdata1;

  modport slave (
    input  flush,
    input  alu_wen, alu_wdst, alu_wbank, alu_wdata,
    input  lsu_valid, lsu_wdst, lsu_wbank, lsu_wdata,
    output lsu_ready,
    input  mul_valid, mul_wdst, mul_wbank, mul_wdata,
    output mul_ready,
    input  sb_set, sb_dst, sb_bank,
    output sb_busy,
    output rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0,
    output rf_wen1, rf_wdst1, rf_wbank1, rf_wdata1
  );

  modport master (
    output flush,
    output alu_wen, alu_wdst, alu_wbank, alu_wdata,
    output lsu_valid, lsu_wdst, lsu_wbank, lsu_wdata,
    input  lsu_ready,
    output mul_valid, mul_wdst, mul_wbank, mul_wdata,
    input  mul_ready,
    output sb_set, sb_dst, sb_bank,
    input  sb_busy,
    input  rf_wen0, rf_wdst0, rf_wbank0, rf_wdata0,
    input  rf_wen1, rf_wdst1, rf_wbank1, rf_wdata1
  );
endinterface

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: writeback arbiter and pending-register scoreboard for the SH-4
// integer register file. Merges ALU (never stalls), LSU (2-entry FIFO) and MUL
// (valid/ready) results onto two registered RF write ports, priority
// ALU > LSU head > MUL, and tracks long-latency writes per physical register.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - rf_wb_arb_if.slave (flush, result sources, scoreboard, RF ports)
module rf_wb_arb (
  input logic        clk,
  input logic        rst,
  rf_wb_arb_if.slave bus
);

  typedef enum logic [1:0] {SRC_ALU, SRC_LSU, SRC_MUL} src_e;

  // Banked R0-R7 live at physical 16..23; everything else maps 1:1.
  function automatic logic [4:0] phys_idx(input logic [3:0] dst, input logic bank);
    phys_idx = (bank && !dst[3]) ? {2'b10, dst[2:0]} : {1'b0, dst};
  endfunction

  // LSU FIFO storage and control
  logic [3:0]  fifo_dst  [2];
  logic        fifo_bank [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic [23:0] busy, busy_next;

  logic        wen0_p1, wen1_p1;
  logic [3:0]  dst0_p1, dst1_p1;
  logic        bank0_p1, bank1_p1;
  logic [31:0] data0_p1, data1_p1;

  logic        has_lsu, has_mul, lsu_ready, push, pop;
  logic        g0, g1, grant_lsu, grant_mul;
  src_e        src0, src1;
  logic [4:0]  idx_alu, idx_lsu, idx_mul, idx_sb;
  logic [3:0]  dst0, dst1;
  logic        bank0, bank1;
  logic [31:0] data0, data1;

  // Stage p0: candidate selection, conflict check and grant
  assign has_lsu   = (count != 2'd0) && !bus.flush;
  assign has_mul   = bus.mul_valid && !bus.flush;
  // Readiness uses the pre-pop count, so a full FIFO may push and pop together
  // only when ready is already high -- i.e. never while full.
  assign lsu_ready = (count != 2'd2) && !bus.flush;
  assign push      = bus.lsu_valid && lsu_ready;
  assign pop       = grant_lsu;

  assign idx_alu = phys_idx(bus.alu_wdst, bus.alu_wbank);
  assign idx_lsu = phys_idx(fifo_dst[rd_ptr], fifo_bank[rd_ptr]);
  assign idx_mul = phys_idx(bus.mul_wdst, bus.mul_wbank);
  assign idx_sb  = phys_idx(bus.sb_dst, bus.sb_bank);

  always_comb begin
    g0   = 1'b0;
    g1   = 1'b0;
    src0 = SRC_ALU;
    src1 = SRC_MUL;
    // Only the top two candidates are considered; a same-index second
    // candidate loses and the third never gets a port.
    if (bus.alu_wen) begin
      g0 = 1'b1;
      if (has_lsu) begin
        if (idx_lsu != idx_alu) begin
          g1   = 1'b1;
          src1 = SRC_LSU;
        end
      end else if (has_mul && (idx_mul != idx_alu)) begin
        g1 = 1'b1;
      end
    end else if (has_lsu) begin
      g0   = 1'b1;
      src0 = SRC_LSU;
      if (has_mul && (idx_mul != idx_lsu)) g1 = 1'b1;
    end else if (has_mul) begin
      g0   = 1'b1;
      src0 = SRC_MUL;
    end
    grant_lsu = (g0 && (src0 == SRC_LSU)) || (g1 && (src1 == SRC_LSU));
    grant_mul = (g0 && (src0 == SRC_MUL)) || (g1 && (src1 == SRC_MUL));
  end

  always_comb begin
    case (src0)
      SRC_ALU: begin dst0 = bus.alu_wdst;      bank0 = bus.alu_wbank;      data0 = bus.alu_wdata;      end
      SRC_LSU: begin dst0 = fifo_dst[rd_ptr];  bank0 = fifo_bank[rd_ptr];  data0 = fifo_data[rd_ptr];  end
      default: begin dst0 = bus.mul_wdst;      bank0 = bus.mul_wbank;      data0 = bus.mul_wdata;      end
    endcase
    if (src1 == SRC_LSU) begin
      dst1 = fifo_dst[rd_ptr]; bank1 = fifo_bank[rd_ptr]; data1 = fifo_data[rd_ptr];
    end else begin
      dst1 = bus.mul_wdst;     bank1 = bus.mul_wbank;     data1 = bus.mul_wdata;
    end
  end

  // Clears go in first so a same-cycle set on the same index wins.
  always_comb begin
    busy_next = busy;
    if (grant_lsu) busy_next[idx_lsu] = 1'b0;
    if (grant_mul) busy_next[idx_mul] = 1'b0;
    if (bus.sb_set) busy_next[idx_sb] = 1'b1;
    if (bus.flush) busy_next = '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dst[wr_ptr]  <= bus.lsu_wdst;
      fifo_bank[wr_ptr] <= bus.lsu_wbank;
      fifo_data[wr_ptr] <= bus.lsu_wdata;
    end
  end

  // Stage p1: registered RF write ports, FIFO pointers and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      busy     <= '0;
      wen0_p1  <= 1'b0;
      wen1_p1  <= 1'b0;
      dst0_p1  <= '0;
      dst1_p1  <= '0;
      bank0_p1 <= 1'b0;
      bank1_p1 <= 1'b0;
      data0_p1 <= '0;
      data1_p1 <= '0;
    end else begin
      busy    <= busy_next;
      wen0_p1 <= g0;
      wen1_p1 <= g1;
      if (g0) begin
        dst0_p1  <= dst0;
        bank0_p1 <= bank0;
        data0_p1 <= data0;
      end
      if (g1) begin
        dst1_p1  <= dst1;
        bank1_p1 <= bank1;
        data1_p1 <= data1;
      end
      if (bus.flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign bus.lsu_ready = lsu_ready;
  assign bus.mul_ready = grant_mul;
  assign bus.sb_busy   = busy;
  assign bus.rf_wen0   = wen0_p1;
  assign bus.rf_wdst0  = dst0_p1;
  assign bus.rf_wbank0 = bank0_p1;
  assign bus.rf_wdata0 = data0_p1;
  assign bus.rf_wen1   = wen1_p1;
  assign bus.rf_wdst1  = dst1_p1;
  assign bus.rf_wbank1 = bank1_p1;
  assign bus.rf_wdata1 = data1_p1;

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: scoreboard bench for rf_wb_arb. A driver applies directed and
// random stimulus, evaluates a queue-based reference model of the arbitration
// rules and pushes the expected registered outputs; a monitor pops and compares
// them one cycle later.
module tb_rf_wb_arb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arb_if bus ();

  rf_wb_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [3:0]  dst;
    logic        bank;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    int  src;   // 0 alu, 1 lsu, 2 mul
    wr_t w;
  } cand_t;

  typedef struct packed {
    logic        wen0;
    wr_t         w0;
    logic        wen1;
    wr_t         w1;
    logic [23:0] busy;
  } exp_t;

  exp_t  exp_q[$];
  wr_t   m_fifo[$];
  logic [23:0] m_busy;
  wr_t   m_hold0, m_hold1;
  logic  exp_lsu_ready, exp_mul_ready;
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic int pidx(input logic [3:0] d, input logic b);
    return (b && d < 4'd8) ? 16 + int'(d) : int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_busy  = '0;
    m_hold0 = '0;
    m_hold1 = '0;
  endtask

  task automatic idle();
    bus.flush     = 1'b0;
    bus.alu_wen   = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.mul_valid = 1'b0;
    bus.sb_set    = 1'b0;
  endtask

  task automatic set_alu(input logic en, input logic [3:0] d, input logic b, input logic [31:0] v);
    bus.alu_wen = en; bus.alu_wdst = d; bus.alu_wbank = b; bus.alu_wdata = v;
  endtask

  task automatic set_lsu(input logic en, input logic [3:0] d, input logic b, input logic [31:0] v);
    bus.lsu_valid = en; bus.lsu_wdst = d; bus.lsu_wbank = b; bus.lsu_wdata = v;
  endtask

  task automatic set_mul(input logic en, input logic [3:0] d, input logic b, input logic [31:0] v);
    bus.mul_valid = en; bus.mul_wdst = d; bus.mul_wbank = b; bus.mul_wdata = v;
  endtask

  task automatic set_sb(input logic en, input logic [3:0] d, input logic b);
    bus.sb_set = en; bus.sb_dst = d; bus.sb_bank = b;
  endtask

  // Called just after a falling edge with inputs applied; evaluates one cycle.
  task automatic step();
    cand_t c[$];
    cand_t t;
    exp_t  e;
    bit    gl, gm;
    int    li, mi;
    #1;
    gl = 0; gm = 0; li = 0; mi = 0;
    if (bus.alu_wen) begin
      t.src = 0; t.w.dst = bus.alu_wdst; t.w.bank = bus.alu_wbank; t.w.data = bus.alu_wdata;
      c.push_back(t);
    end
    if (!bus.flush && m_fifo.size() > 0) begin
      t.src = 1; t.w = m_fifo[0];
      c.push_back(t);
    end
    if (!bus.flush && bus.mul_valid) begin
      t.src = 2; t.w.dst = bus.mul_wdst; t.w.bank = bus.mul_wbank; t.w.data = bus.mul_wdata;
      c.push_back(t);
    end
    e.wen0 = 1'b0; e.wen1 = 1'b0; e.w0 = m_hold0; e.w1 = m_hold1;
    if (c.size() >= 1) begin
      e.wen0 = 1'b1; e.w0 = c[0].w;
      if (c[0].src == 1) gl = 1;
      if (c[0].src == 2) gm = 1;
    end
    if (c.size() >= 2 && pidx(c[1].w.dst, c[1].w.bank) != pidx(c[0].w.dst, c[0].w.bank)) begin
      e.wen1 = 1'b1; e.w1 = c[1].w;
      if (c[1].src == 1) gl = 1;
      if (c[1].src == 2) gm = 1;
    end
    exp_mul_ready = gm;
    exp_lsu_ready = !bus.flush && (m_fifo.size() < 2);
    check("mul_ready", {31'b0, bus.mul_ready}, {31'b0, exp_mul_ready});
    check("lsu_ready", {31'b0, bus.lsu_ready}, {31'b0, exp_lsu_ready});
    if (gl) begin
      li = pidx(m_fifo[0].dst, m_fifo[0].bank);
      m_busy[li] = 1'b0;
      void'(m_fifo.pop_front());
    end
    if (gm) begin
      mi = pidx(bus.mul_wdst, bus.mul_wbank);
      m_busy[mi] = 1'b0;
    end
    if (bus.lsu_valid && exp_lsu_ready) begin
      t.w.dst = bus.lsu_wdst; t.w.bank = bus.lsu_wbank; t.w.data = bus.lsu_wdata;
      m_fifo.push_back(t.w);
    end
    if (bus.sb_set && !bus.flush) m_busy[pidx(bus.sb_dst, bus.sb_bank)] = 1'b1;
    if (bus.flush) begin
      m_fifo.delete();
      m_busy = '0;
    end
    m_hold0 = e.w0;
    m_hold1 = e.w1;
    e.busy  = m_busy;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: registered outputs appear after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_wen0",   {31'b0, bus.rf_wen0},   {31'b0, e.wen0});
        check("rf_wdst0",  {28'b0, bus.rf_wdst0},  {28'b0, e.w0.dst});
        check("rf_wbank0", {31'b0, bus.rf_wbank0}, {31'b0, e.w0.bank});
        check("rf_wdata0", bus.rf_wdata0, e.w0.data);
        check("rf_wen1",   {31'b0, bus.rf_wen1},   {31'b0, e.wen1});
        check("rf_wdst1",  {28'b0, bus.rf_wdst1},  {28'b0, e.w1.dst});
        check("rf_wbank1", {31'b0, bus.rf_wbank1}, {31'b0, e.w1.bank});
        check("rf_wdata1", bus.rf_wdata1, e.w1.data);
        check("sb_busy",   {8'b0, bus.sb_busy},    {8'b0, e.busy});
      end
    end
  end

  initial begin
    bit lsu_acc, mul_acc;
    rst = 1'b1;
    idle();
    set_alu(0, 0, 0, 0); set_lsu(0, 0, 0, 0); set_mul(0, 0, 0, 0); set_sb(0, 0, 0);
    model_reset();
    #1;
    check("reset rf_wen0", {31'b0, bus.rf_wen0}, 32'd0);
    check("reset rf_wen1", {31'b0, bus.rf_wen1}, 32'd0);
    check("reset rf_wdata0", bus.rf_wdata0, 32'd0);
    check("reset sb_busy", {8'b0, bus.sb_busy}, 32'd0);
    check("reset mul_ready", {31'b0, bus.mul_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ALU R3 + MUL R5 go out together
    set_alu(1, 3, 0, 32'h11); set_mul(1, 5, 0, 32'h22); step();
    idle(); step();

    // ALU R1, LSU head R2, MUL R4: MUL waits one cycle
    set_lsu(1, 2, 0, 32'h33); step();
    set_lsu(0, 0, 0, 0);
    set_alu(1, 1, 0, 32'h44); set_mul(1, 4, 0, 32'h55); step();
    set_alu(0, 0, 0, 0); step();
    idle(); step();

    // Same-register conflict, then banked alias which is not a conflict
    set_lsu(1, 6, 0, 32'h66); step();
    set_lsu(0, 0, 0, 0); set_alu(1, 6, 0, 32'h77); step();
    idle(); step(); step();
    set_lsu(1, 6, 1, 32'h88); step();
    set_lsu(0, 0, 0, 0); set_alu(1, 6, 0, 32'h99); step();
    idle(); step();

    // Fill the FIFO behind a blocking ALU write; then let it drain in order
    set_alu(1, 7, 0, 32'h1); set_mul(1, 10, 0, 32'h2);
    set_lsu(1, 7, 0, 32'hA0); step();
    set_lsu(1, 7, 0, 32'hA1); step();
    set_lsu(1, 7, 0, 32'hA2); step();
    set_lsu(0, 0, 0, 0); set_alu(0, 0, 0, 0); step(); step();
    idle(); step(); step();

    // Scoreboard set / clear / set-wins
    set_sb(1, 9, 0); step();
    set_sb(0, 0, 0); set_mul(1, 9, 0, 32'h123); step();
    set_mul(0, 0, 0, 0); set_sb(1, 9, 0); step();
    set_sb(1, 9, 0); set_mul(1, 9, 0, 32'h456); step();
    idle(); step();
    set_mul(1, 9, 0, 32'h789); step();
    idle(); step();

    // Flush with two FIFO entries and busy R8/R9
    set_sb(1, 8, 0); set_alu(1, 0, 0, 32'hB0); set_lsu(1, 0, 0, 32'hC0); step();
    set_sb(1, 9, 0); set_lsu(1, 0, 0, 32'hC1); step();
    set_sb(1, 11, 0); set_lsu(0, 0, 0, 0); bus.flush = 1'b1; set_mul(1, 12, 0, 32'hD0); step();
    idle(); step(); step();

    // Async reset while the FIFO drains
    set_sb(1, 3, 1); set_alu(1, 2, 0, 32'hE0); set_lsu(1, 2, 0, 32'hF0); step();
    set_sb(0, 0, 0); set_lsu(1, 2, 0, 32'hF1); step();
    idle(); step();
    #2 rst = 1'b1;
    #1;
    check("async rf_wen0", {31'b0, bus.rf_wen0}, 32'd0);
    check("async rf_wdst0", {28'b0, bus.rf_wdst0}, 32'd0);
    check("async rf_wdata0", bus.rf_wdata0, 32'd0);
    check("async sb_busy", {8'b0, bus.sb_busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(); step();

    // Randomized traffic
    lsu_acc = 1; mul_acc = 1;
    for (int i = 0; i < 600; i++) begin
      set_alu(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), $urandom);
      if (!bus.lsu_valid || lsu_acc)
        set_lsu(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), $urandom);
      if (!bus.mul_valid || mul_acc)
        set_mul(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), $urandom);
      set_sb(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      bus.flush = ($urandom_range(0, 24) == 0);
      step();
      lsu_acc = bus.lsu_valid && exp_lsu_ready;
      mul_acc = exp_mul_ready;
    end

    idle();
    repeat (4) step();
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
